core: RTL and testbench

CORE -- requirements
Module: core

---
 rtl/core.sv | 96 +++++++++
 tb/tb_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/core.sv
// Single-cycle accumulator core: one instruction per rising edge, fetched from an
// external program memory addressed by PC, with a 4-entry register file.
module core #(
  parameter int PC_LEN    = 7,
  parameter int DATA_LEN  = 8,
  parameter int INSTR_LEN = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [DATA_LEN-2:0]  IPORT,
  input  logic [INSTR_LEN-1:0] INSTR,
  output logic [DATA_LEN-2:0]  OPORT,
  output logic [PC_LEN-1:0]    PC
);

  localparam int NUM_REGS = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_LD  = 4'd5, OP_ST  = 4'd6, OP_SHL = 4'd7,
    OP_SHR = 4'd8, OP_IN  = 4'd9, OP_OUT = 4'd10, OP_NOT = 4'd11
  } reg_op_t;

  logic [DATA_LEN-1:0] acc_reg, acc_next;
  logic [DATA_LEN-1:0] r_reg [NUM_REGS];
  logic [NUM_REGS-1:0] r_we;
  logic [PC_LEN-1:0]   pc_next;
  logic [DATA_LEN-2:0] oport_next;
  logic                st_sel;

  logic [3:0]          op;
  logic [1:0]          rsel;
  logic [DATA_LEN-1:0] imm;
  logic [DATA_LEN-1:0] operand;

  assign op      = INSTR[5:2];
  assign rsel    = INSTR[1:0];
  assign imm     = {{(DATA_LEN-5){INSTR[4]}}, INSTR[4:0]};
  assign operand = r_reg[rsel];

  // Only ST writes the register file; it stores the pre-edge accumulator.
  assign st_sel = (INSTR[7:6] == 2'b00) && (op == OP_ST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
      assign r_we[gi] = st_sel && (rsel == gi[1:0]);
    end
  endgenerate

  always_comb begin
    acc_next   = acc_reg;
    pc_next    = PC + PC_LEN'(1);
    oport_next = OPORT;
    if (INSTR[7]) begin
      // N flag is simply the accumulator sign bit.
      if (acc_reg[DATA_LEN-1])
        pc_next = INSTR[PC_LEN-1:0];
    end else if (INSTR[6]) begin
      acc_next = INSTR[5] ? (acc_reg + imm) : imm;
    end else begin
      case (op)
        OP_ADD:  acc_next = acc_reg + operand;
        OP_SUB:  acc_next = acc_reg - operand;
        OP_AND:  acc_next = acc_reg & operand;
        OP_OR:   acc_next = acc_reg | operand;
        OP_XOR:  acc_next = acc_reg ^ operand;
        OP_LD:   acc_next = operand;
        OP_SHL:  acc_next = acc_reg << 1;
        OP_SHR:  acc_next = acc_reg >> 1;
        OP_IN:   acc_next = {1'b0, IPORT};
        OP_OUT:  oport_next = acc_reg[DATA_LEN-2:0];
        OP_NOT:  acc_next = ~acc_reg;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      PC      <= '0;
      acc_reg <= '0;
      OPORT   <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        r_reg[i] <= '0;
    end else begin
      PC      <= pc_next;
      acc_reg <= acc_next;
      OPORT   <= oport_next;
      for (int i = 0; i < NUM_REGS; i++)
        if (r_we[i])
          r_reg[i] <= acc_reg;
    end
  end

endmodule

// File: tb/tb_core.sv
// Bench for core: an ISA-level reference model predicts PC/OPORT per edge into a
// scoreboard queue, compared after each rising edge, plus directed program checks.
module tb_core;

  logic       CLK;
  logic       RSTN;
  logic [6:0] IPORT;
  logic [7:0] INSTR;
  logic [6:0] OPORT;
  logic [6:0] PC;

  core #(.PC_LEN(7), .DATA_LEN(8), .INSTR_LEN(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .IPORT(IPORT), .INSTR(INSTR), .OPORT(OPORT), .PC(PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [6:0] pc;
    logic [6:0] op;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] prog [128];
  int         n_cmp = 0;
  int         n_bad = 0;

  // reference model state
  logic [7:0] m_acc;
  logic [7:0] m_r [4];
  logic [6:0] m_pc;
  logic [6:0] m_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 8'h00;
    m_pc  = 7'h00;
    m_op  = 7'h00;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endtask

  task automatic model_exec(input logic [7:0] ins, input logic [6:0] ip);
    logic [7:0] rv;
    logic [7:0] sx;
    logic [6:0] npc;
    rv  = m_r[ins[1:0]];
    sx  = {{3{ins[4]}}, ins[4:0]};
    npc = m_pc + 7'd1;
    casez (ins)
      8'b1???????: if (m_acc[7]) npc = ins[6:0];
      8'b010?????: m_acc = sx;
      8'b011?????: m_acc = m_acc + sx;
      8'b000000??: m_acc = m_acc + rv;
      8'b000001??: m_acc = m_acc - rv;
      8'b000010??: m_acc = m_acc & rv;
      8'b000011??: m_acc = m_acc | rv;
      8'b000100??: m_acc = m_acc ^ rv;
      8'b000101??: m_acc = rv;
      8'b000110??: m_r[ins[1:0]] = m_acc;
      8'b000111??: m_acc = {m_acc[6:0], 1'b0};
      8'b001000??: m_acc = {1'b0, m_acc[7:1]};
      8'b001001??: m_acc = {1'b0, ip};
      8'b001010??: m_op  = m_acc[6:0];
      8'b001011??: m_acc = ~m_acc;
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic load(input logic [7:0] p[$]);
    for (int i = 0; i < 128; i++) prog[i] = 8'h30;
    foreach (p[i]) prog[i] = p[i];
  endtask

  // One clock: drive at the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic rst);
    exp_t e;
    @(negedge CLK);
    RSTN  = rst;
    INSTR = rst ? 8'($urandom) : prog[PC];
    if (rst) model_reset();
    else     model_exec(prog[m_pc], IPORT);
    e.pc = m_pc;
    e.op = m_op;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("sb_pc", 32'(PC), 32'(e.pc));
    chk("sb_oport", 32'(OPORT), 32'(e.op));
  endtask

  initial begin
    RSTN  = 1'b1;
    INSTR = 8'h00;
    IPORT = 7'h00;
    model_reset();

    // reset with garbage instructions, then a NOP at address 0
    load('{});
    repeat (4) step(1'b1);
    chk("rst_pc", 32'(PC), 32'h00);
    chk("rst_oport", 32'(OPORT), 32'h00);
    step(1'b0);
    chk("nop_pc", 32'(PC), 32'h01);

    // LDI 5, ADDI 3, OUT
    load('{8'h45, 8'h63, 8'h28});
    step(1'b1);
    repeat (3) step(1'b0);
    chk("addi_oport", 32'(OPORT), 32'h08);
    chk("addi_pc", 32'(PC), 32'h03);

    // BRN taken / not taken
    load('{8'h5F, 8'h85});
    step(1'b1);
    repeat (2) step(1'b0);
    chk("brn_taken_pc", 32'(PC), 32'h05);
    load('{8'h41, 8'h85});
    step(1'b1);
    repeat (2) step(1'b0);
    chk("brn_not_taken_pc", 32'(PC), 32'h02);

    // IN, ST R1, LDI 1, SUB R1, OUT, BRN 0x10 (taken only if ACC=0xD7 is negative)
    IPORT = 7'h2A;
    load('{8'h24, 8'h19, 8'h41, 8'h05, 8'h28, 8'h90});
    step(1'b1);
    repeat (6) step(1'b0);
    chk("sub_oport", 32'(OPORT), 32'h57);
    chk("sub_acc_neg_pc", 32'(PC), 32'h10);

    // halt idiom
    load('{8'h5F, 8'h81});
    step(1'b1);
    repeat (2) step(1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      chk("halt_pc", 32'(PC), 32'h01);
    end

    // reset clears ACC: BRN at address 0 must fall through
    load('{8'h85});
    step(1'b1);
    step(1'b0);
    chk("rst_acc_brn_pc", 32'(PC), 32'h01);

    // random programs against the reference model
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 128; i++) prog[i] = 8'($urandom);
      step(1'b1);
      for (int i = 0; i < 60; i++) begin
        IPORT = 7'($urandom);
        step(1'b0);
      end
    end

    // all-NOP wrap and mid-program reset
    load('{});
    step(1'b1);
    repeat (128) step(1'b0);
    chk("wrap_pc", 32'(PC), 32'h00);
    repeat (64) step(1'b0);
    chk("mid_pc", 32'(PC), 32'h40);
    step(1'b1);
    chk("mid_rst_pc", 32'(PC), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
